// File: rtl/dcache_sa_controller.sv
// ---------------------------------------------------------------------------
// dcache_sa_controller
//   N-way set-associative write-back / write-allocate data cache for the MEM
//   stage of a 5-stage pipeline. Lookups are combinational, so a hit costs no
//   cycles. A miss stalls the pipeline while the victim line is written back
//   (when dirty) and the requested line is refilled from the 256-bit line
//   memory. Replacement is true LRU. Hits and misses are counted with
//   saturating counters.
//
// Ports
//   clk_i, rst_i                   clock, asynchronous active-high reset
//   cpu_addr_i / cpu_data_i        byte address (held during stall) / store data
//   cpu_MemRead_i, cpu_MemWrite_i  load / store request (both high = store)
//   cpu_data_o                     load data (0 unless a read hit)
//   cpu_stall_o                    hold the pipeline
//   mem_data_i, mem_ack_i          refill line, 1-cycle completion pulse
//   mem_data_o, mem_addr_o         write-back line, line address ([4:0]=0)
//   mem_enable_o, mem_write_o      request, 1 = write-back / 0 = refill read
//   hit_cnt_o, miss_cnt_o          saturating hit / miss counters
// ---------------------------------------------------------------------------
module dcache_sa_controller #(
   parameter int NUM_WAYS = 2,
   parameter int NUM_SETS = 16,
   parameter int LINE_W   = 256,
   parameter int CNT_W    = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [31:0]       cpu_addr_i,
   input  logic [31:0]       cpu_data_i,
   input  logic              cpu_MemRead_i,
   input  logic              cpu_MemWrite_i,
   output logic [31:0]       cpu_data_o,
   output logic              cpu_stall_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i,
   output logic [LINE_W-1:0] mem_data_o,
   output logic [31:0]       mem_addr_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [CNT_W-1:0]  hit_cnt_o,
   output logic [CNT_W-1:0]  miss_cnt_o
);

   localparam int WAY_W = $clog2(NUM_WAYS);
   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int TAG_W = 32 - 5 - IDX_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MISS,
      S_WB_REQ,
      S_RD_REQ,
      S_REFILL
   } state_t;

   state_t r_state, w_state_n;

   // per way / set storage; only the status bits are reset
   logic              r_valid [NUM_WAYS][NUM_SETS];
   logic              r_dirty [NUM_WAYS][NUM_SETS];
   logic [WAY_W-1:0]  r_age   [NUM_WAYS][NUM_SETS];
   logic [TAG_W-1:0]  r_tag   [NUM_WAYS][NUM_SETS];
   logic [LINE_W-1:0] r_data  [NUM_WAYS][NUM_SETS];

   logic [WAY_W-1:0]  r_victim;
   logic [LINE_W-1:0] r_line;
   logic              r_refilled;
   logic [CNT_W-1:0]  r_hit_cnt;
   logic [CNT_W-1:0]  r_miss_cnt;

   logic [TAG_W-1:0]  w_tag;
   logic [IDX_W-1:0]  w_idx;
   logic [2:0]        w_word;
   logic              w_req;
   logic              w_is_wr;
   logic              w_hit;
   logic [WAY_W-1:0]  w_hit_way;
   logic [LINE_W-1:0] w_hit_line;
   logic [31:0]       w_hit_word;
   logic [WAY_W-1:0]  w_old_age;
   logic              w_access;
   logic              w_miss;
   logic [WAY_W-1:0]  w_victim;
   logic              w_inv_found;
   logic              w_unused;

   assign w_tag    = cpu_addr_i[31:5+IDX_W];
   assign w_idx    = cpu_addr_i[4+IDX_W:5];
   assign w_word   = cpu_addr_i[4:2];
   assign w_unused = ^cpu_addr_i[1:0];
   assign w_req    = cpu_MemRead_i | cpu_MemWrite_i;
   assign w_is_wr  = cpu_MemWrite_i;

   // ---------------- lookup ----------------
   always_comb begin
      w_hit     = 1'b0;
      w_hit_way = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
            w_hit     = 1'b1;
            w_hit_way = WAY_W'(w);
         end
      end
   end

   assign w_hit_line = r_data[w_hit_way][w_idx];
   assign w_hit_word = w_hit_line[{w_word, 5'b0} +: 32];
   assign w_old_age  = r_age[w_hit_way][w_idx];

   // an access completes only on an IDLE hit; a miss is recorded in IDLE
   assign w_access = (r_state == S_IDLE) && w_req && w_hit;
   assign w_miss   = (r_state == S_IDLE) && w_req && !w_hit;

   // ---------------- victim selection ----------------
   // lowest-index invalid way first, otherwise the least recently used way
   always_comb begin
      w_victim    = '0;
      w_inv_found = 1'b0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (!w_inv_found && !r_valid[w][w_idx]) begin
            w_victim    = WAY_W'(w);
            w_inv_found = 1'b1;
         end
      end
      if (!w_inv_found) begin
         for (int w = 0; w < NUM_WAYS; w++) begin
            if (r_age[w][w_idx] == WAY_W'(NUM_WAYS - 1)) w_victim = WAY_W'(w);
         end
      end
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_n;
   end

   always_comb begin
      w_state_n    = r_state;
      cpu_stall_o  = 1'b0;
      cpu_data_o   = '0;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      case (r_state)
         S_IDLE: begin
            if (w_miss) begin
               cpu_stall_o = 1'b1;
               w_state_n   = S_MISS;
            end
            if (w_hit && cpu_MemRead_i && !cpu_MemWrite_i) cpu_data_o = w_hit_word;
         end
         S_MISS: begin
            cpu_stall_o = 1'b1;
            if (r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx]) w_state_n = S_WB_REQ;
            else                                                       w_state_n = S_RD_REQ;
         end
         S_WB_REQ: begin
            cpu_stall_o  = 1'b1;
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {r_tag[r_victim][w_idx], w_idx, 5'b0};
            mem_data_o   = r_data[r_victim][w_idx];
            // back through MISS so enable drops for a cycle between requests
            if (mem_ack_i) w_state_n = S_MISS;
         end
         S_RD_REQ: begin
            cpu_stall_o  = 1'b1;
            mem_enable_o = 1'b1;
            mem_addr_o   = {w_tag, w_idx, 5'b0};
            if (mem_ack_i) w_state_n = S_REFILL;
         end
         S_REFILL: begin
            cpu_stall_o = 1'b1;
            w_state_n   = S_IDLE;
         end
         default: w_state_n = S_IDLE;
      endcase
      // outputs are quiet for as long as reset is held
      if (rst_i) begin
         cpu_stall_o  = 1'b0;
         cpu_data_o   = '0;
         mem_enable_o = 1'b0;
         mem_write_o  = 1'b0;
         mem_addr_o   = '0;
         mem_data_o   = '0;
      end
   end

   // ---------------- status, LRU and counters ----------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int w = 0; w < NUM_WAYS; w++) begin
            for (int s = 0; s < NUM_SETS; s++) begin
               r_valid[w][s] <= 1'b0;
               r_dirty[w][s] <= 1'b0;
               r_age[w][s]   <= WAY_W'(w);
            end
         end
         r_victim   <= '0;
         r_refilled <= 1'b0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (r_state == S_MISS) r_victim <= w_victim;
         if (r_state == S_IDLE) r_refilled <= 1'b0;

         if (w_access) begin
            // most recent -> 0, everything younger than it ages by one
            for (int w = 0; w < NUM_WAYS; w++) begin
               if (WAY_W'(w) == w_hit_way)
                  r_age[w][w_idx] <= '0;
               else if (r_age[w][w_idx] < w_old_age)
                  r_age[w][w_idx] <= r_age[w][w_idx] + 1'b1;
            end
            if (w_is_wr) r_dirty[w_hit_way][w_idx] <= 1'b1;
            // the re-lookup that finishes a refilled miss is not a hit
            if (!r_refilled && (r_hit_cnt != '1)) r_hit_cnt <= r_hit_cnt + 1'b1;
         end

         if (w_miss && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 1'b1;

         if ((r_state == S_WB_REQ) && mem_ack_i) r_dirty[r_victim][w_idx] <= 1'b0;

         if (r_state == S_REFILL) begin
            r_valid[r_victim][w_idx] <= 1'b1;
            r_dirty[r_victim][w_idx] <= 1'b0;
            r_refilled               <= 1'b1;
         end
      end
   end

   // ---------------- tag / data arrays (not reset) ----------------
   always_ff @(posedge clk_i) begin
      if ((r_state == S_RD_REQ) && mem_ack_i) r_line <= mem_data_i;
      if (r_state == S_REFILL) begin
         r_data[r_victim][w_idx] <= r_line;
         r_tag[r_victim][w_idx]  <= w_tag;
      end
      if (w_access && w_is_wr) r_data[w_hit_way][w_idx][{w_word, 5'b0} +: 32] <= cpu_data_i;
   end

   assign hit_cnt_o  = r_hit_cnt;
   assign miss_cnt_o = r_miss_cnt;

endmodule

// File: tb/tb_dcache_sa_controller.sv
// Testbench for dcache_sa_controller (2 ways, 16 sets). A behavioural line
// memory acks 10 cycles after enable rises and keeps written-back lines.
// Unwritten line L holds word k = 0xC0DE0000 + L + k.
module tb_dcache_sa_controller;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic [31:0]  cpu_addr_i;
   logic [31:0]  cpu_data_i;
   logic         cpu_MemRead_i;
   logic         cpu_MemWrite_i;
   logic [31:0]  cpu_data_o;
   logic         cpu_stall_o;
   logic [255:0] mem_data_i;
   logic         mem_ack_i;
   logic [255:0] mem_data_o;
   logic [31:0]  mem_addr_o;
   logic         mem_enable_o;
   logic         mem_write_o;
   logic [31:0]  hit_cnt_o;
   logic [31:0]  miss_cnt_o;

   dcache_sa_controller #(.NUM_WAYS(2), .NUM_SETS(16), .LINE_W(256), .CNT_W(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
      .cpu_MemRead_i(cpu_MemRead_i), .cpu_MemWrite_i(cpu_MemWrite_i),
      .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
      .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
      .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
      .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   // ---------------- memory model ----------------
   logic [255:0] mem [logic [31:0]];
   int           mcnt = 0;
   logic         prev_en = 1'b0;
   int           ntx = 0;
   int           nstart = 0;
   logic         tx_wr [16];
   logic [31:0]  tx_addr [16];
   logic [31:0]  tx_w1 [16];

   function automatic logic [255:0] line_for(input logic [31:0] a);
      logic [255:0] l;
      if (mem.exists(a)) return mem[a];
      for (int k = 0; k < 8; k++) l[32*k +: 32] = 32'hC0DE_0000 + a + k;
      return l;
   endfunction

   initial begin
      mem_ack_i  = 1'b0;
      mem_data_i = '0;
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            mcnt = 0; mem_ack_i = 1'b0; prev_en = 1'b0;
         end else if (mem_ack_i) begin
            mem_ack_i = 1'b0; mcnt = 0; prev_en = mem_enable_o;
         end else begin
            if (mem_enable_o) begin
               if (!prev_en) nstart++;
               mcnt++;
               if (mcnt == 10) begin
                  mem_ack_i = 1'b1;
                  if (ntx < 16) begin
                     tx_wr[ntx] = mem_write_o; tx_addr[ntx] = mem_addr_o;
                     tx_w1[ntx] = mem_data_o[63:32];
                  end
                  ntx++;
                  if (mem_write_o) mem[mem_addr_o] = mem_data_o;
                  else             mem_data_i = line_for(mem_addr_o);
               end
            end else mcnt = 0;
            prev_en = mem_enable_o;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic idle();
      cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b1; idle();
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      ntx = 0; nstart = 0;
   endtask

   // Drives one access and waits (bounded) for it to complete.
   task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input string nm,
                            output int ncyc, output logic stall0, output logic [31:0] data);
      @(negedge clk_i);
      cpu_MemRead_i = rd; cpu_MemWrite_i = wr; cpu_addr_i = addr; cpu_data_i = wdata;
      #1;
      stall0 = cpu_stall_o;
      ncyc = 0;
      while (cpu_stall_o && ncyc < 200) begin
         ncyc++;
         @(negedge clk_i); #1;
      end
      data = cpu_data_o;
      @(posedge clk_i); #1;
   endtask

   typedef struct {
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          stall_cyc;
      logic [31:0] rdata;
      logic [31:0] hits;
      logic [31:0] misses;
   } vec_t;

   vec_t vt[17];

   task automatic run_vecs(input int lo, input int hi);
      int n; logic s0; logic [31:0] d;
      for (int i = lo; i <= hi; i++) begin
         do_access(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, $sformatf("v%0d", i), n, s0, d);
         chk($sformatf("v%0d_stall0", i), {31'b0, s0}, {31'b0, vt[i].stall_cyc != 0});
         chk($sformatf("v%0d_stallcyc", i), n, vt[i].stall_cyc);
         chk($sformatf("v%0d_data", i), d, vt[i].rdata);
         chk($sformatf("v%0d_hitcnt", i), hit_cnt_o, vt[i].hits);
         chk($sformatf("v%0d_misscnt", i), miss_cnt_o, vt[i].misses);
      end
      @(negedge clk_i); idle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: got running, want finished");
      $fatal(1);
   end

   initial begin
      int nwr; int k; int n; logic s0; logic [31:0] d;

      // clean miss = 13 stall cycles, dirty-victim miss = 24
      vt[0]  = '{1'b1, 1'b0, 32'h400, 32'h0,        13, 32'hC0DE0400, 32'd0, 32'd1};
      vt[1]  = '{1'b0, 1'b1, 32'h404, 32'hDEADBEEF,  0, 32'h0,        32'd1, 32'd1};
      vt[2]  = '{1'b1, 1'b0, 32'h404, 32'h0,         0, 32'hDEADBEEF, 32'd2, 32'd1};
      vt[3]  = '{1'b1, 1'b0, 32'h600, 32'h0,        13, 32'hC0DE0600, 32'd2, 32'd2};
      vt[4]  = '{1'b1, 1'b0, 32'h800, 32'h0,        24, 32'hC0DE0800, 32'd2, 32'd3};
      vt[5]  = '{1'b1, 1'b0, 32'h404, 32'h0,        13, 32'hDEADBEEF, 32'd2, 32'd4};
      vt[6]  = '{1'b1, 1'b0, 32'h41C, 32'h0,         0, 32'hC0DE0407, 32'd3, 32'd4};
      vt[7]  = '{1'b1, 1'b0, 32'h810, 32'h0,         0, 32'hC0DE0804, 32'd4, 32'd4};
      vt[8]  = '{1'b1, 1'b0, 32'h420, 32'h0,        13, 32'hC0DE0420, 32'd4, 32'd5};
      vt[9]  = '{1'b1, 1'b1, 32'h424, 32'h12345678,  0, 32'h0,        32'd5, 32'd5};
      vt[10] = '{1'b1, 1'b0, 32'h424, 32'h0,         0, 32'h12345678, 32'd6, 32'd5};
      // LRU sequence from reset
      vt[11] = '{1'b1, 1'b0, 32'h400, 32'h0,        13, 32'hC0DE0400, 32'd0, 32'd1};
      vt[12] = '{1'b1, 1'b0, 32'h600, 32'h0,        13, 32'hC0DE0600, 32'd0, 32'd2};
      vt[13] = '{1'b1, 1'b0, 32'h400, 32'h0,         0, 32'hC0DE0400, 32'd1, 32'd2};
      vt[14] = '{1'b1, 1'b0, 32'h800, 32'h0,        13, 32'hC0DE0800, 32'd1, 32'd3};
      vt[15] = '{1'b1, 1'b0, 32'h400, 32'h0,         0, 32'hC0DE0400, 32'd2, 32'd3};
      vt[16] = '{1'b1, 1'b0, 32'h600, 32'h0,        13, 32'hC0DE0600, 32'd2, 32'd4};

      // ---- reset: outputs quiet even with a request pending ----
      rst_i = 1'b1; idle();
      cpu_MemRead_i = 1'b1; cpu_addr_i = 32'h400;
      repeat (3) @(negedge clk_i);
      #1;
      chk("rst_stall",   {31'b0, cpu_stall_o}, 32'd0);
      chk("rst_data",    cpu_data_o, 32'd0);
      chk("rst_enable",  {31'b0, mem_enable_o}, 32'd0);
      chk("rst_write",   {31'b0, mem_write_o}, 32'd0);
      chk("rst_addr",    mem_addr_o, 32'd0);
      chk("rst_memdata", {31'b0, |mem_data_o}, 32'd0);
      chk("rst_hit",     hit_cnt_o, 32'd0);
      chk("rst_miss",    miss_cnt_o, 32'd0);
      @(negedge clk_i); idle(); rst_i = 1'b0;
      ntx = 0; nstart = 0;
      repeat (2) @(negedge clk_i);
      #1;
      chk("post_rst_hit",   hit_cnt_o, 32'd0);
      chk("post_rst_miss",  miss_cnt_o, 32'd0);
      chk("post_rst_stall", {31'b0, cpu_stall_o}, 32'd0);

      // ---- cold miss, store/load hits, eviction with write-back ----
      run_vecs(0, 4);
      chk("wb_ntx",    ntx, 4);
      chk("wb_starts", nstart, 4);   // enable dropped between every transaction
      chk("tx0_addr",  tx_addr[0], 32'h400);
      chk("tx0_wr",    {31'b0, tx_wr[0]}, 32'd0);
      chk("tx2_wr",    {31'b0, tx_wr[2]}, 32'd1);
      chk("tx2_addr",  tx_addr[2], 32'h400);
      chk("tx2_word1", tx_w1[2], 32'hDEADBEEF);
      chk("tx3_wr",    {31'b0, tx_wr[3]}, 32'd0);
      chk("tx3_addr",  tx_addr[3], 32'h800);
      run_vecs(5, 10);

      // ---- LRU replacement ----
      do_reset();
      run_vecs(11, 16);
      nwr = 0;
      for (int i = 0; i < ntx && i < 16; i++) if (tx_wr[i]) nwr++;
      chk("lru_ntx", ntx, 4);
      chk("lru_no_wb", nwr, 0);

      // ---- reset in the middle of a refill ----
      do_reset();
      run_vecs(11, 11);                         // miss_cnt now 1
      @(negedge clk_i);
      cpu_MemRead_i = 1'b1; cpu_addr_i = 32'h460;
      k = 0;
      while (!mem_enable_o && k < 50) begin @(negedge clk_i); k++; end
      chk("rr_en_seen", {31'b0, mem_enable_o}, 32'd1);
      repeat (3) @(negedge clk_i);
      #3 rst_i = 1'b1;
      #1;
      chk("rr_en_drop",   {31'b0, mem_enable_o}, 32'd0);
      chk("rr_stall",     {31'b0, cpu_stall_o}, 32'd0);
      chk("rr_miss_zero", miss_cnt_o, 32'd0);
      @(negedge clk_i); idle();
      @(negedge clk_i); rst_i = 1'b0;
      @(negedge clk_i); #1;
      chk("rr_hit_after",  hit_cnt_o, 32'd0);
      chk("rr_miss_after", miss_cnt_o, 32'd0);
      chk("rr_en_after",   {31'b0, mem_enable_o}, 32'd0);
      do_access(1'b1, 1'b0, 32'h400, 32'h0, "rr_reload", n, s0, d);
      chk("rr_reload_stall0", {31'b0, s0}, 32'd1);
      chk("rr_reload_cyc",    n, 13);
      chk("rr_reload_data",   d, 32'hC0DE0400);
      chk("rr_reload_miss",   miss_cnt_o, 32'd1);
      chk("rr_reload_hit",    hit_cnt_o, 32'd0);
      @(negedge clk_i); idle();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
